// File: rtl/pipelined_full_adder.sv
// -----------------------------------------------------------------------------
// pipelined_full_adder
//   Registered WIDTH-bit unsigned ripple-carry adder. Computes a + b + cin
//   through a chain of WIDTH full-adder cells and registers sum/cout one clock
//   after the operands are accepted (in_valid high at a rising clk edge).
//   Outputs hold their last value while in_valid is low.
//
// Parameters
//   WIDTH     operand and sum width, legal range 1..64 (default 1)
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (priority over in_valid)
//   in_valid  a/b/cin carry a valid operand set this cycle
//   a, b      WIDTH-bit unsigned operands
//   cin       carry-in
//   out_valid sum/cout hold a freshly captured result this cycle
//   sum       registered low WIDTH bits of a + b + cin
//   cout      registered bit WIDTH of a + b + cin
//   ovf       registered signed two's-complement overflow of a + b + cin;
//             present only when the ADDER_OVF_EN macro is defined
// -----------------------------------------------------------------------------
module pipelined_full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("pipelined_full_adder: WIDTH must be in 1..64");
        end
    endgenerate

    // carry[i] is the carry into cell i; carry[0] is cin, carry[WIDTH] is cout.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    always_comb begin
        carry    = '0;
        sum_comb = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_comb[i]  = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    // Result registers only load on in_valid, so X on the operands while
    // in_valid is low never reaches the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_comb;
                cout <= carry[WIDTH];
`ifdef ADDER_OVF_EN
                // Overflow when the carry into the sign bit differs from the
                // carry out of it; for WIDTH=1 the carry into the sign is cin.
                ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipelined_full_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_full_adder
//   Self-checking bench for pipelined_full_adder. Two instances are exercised:
//   WIDTH=1 (exhaustive truth table) and WIDTH=8 (carry chain, hold, reset,
//   streaming random vectors, overflow when ADDER_OVF_EN is defined).
//   Expected values come from integer arithmetic on a + b + cin.
// -----------------------------------------------------------------------------
module tb_pipelined_full_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       v1, cin1, a1, b1;
    logic       ov1, s1, co1;
    logic       v8, cin8;
    logic [7:0] a8, b8;
    logic       ov8, co8;
    logic [7:0] s8;
`ifdef ADDER_OVF_EN
    logic       of1, of8;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_full_adder #(.WIDTH(1)) u_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (ov1),
        .sum       (s1),
        .cout      (co1)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (of1)
`endif
    );

    pipelined_full_adder #(.WIDTH(8)) u_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (ov8),
        .sum       (s8),
        .cout      (co8)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (of8)
`endif
    );

    // Reference: {ovf, cout, sum} of a + b + cin for a w-bit adder.
    // Overflow is judged by whether the signed sum leaves the w-bit range.
    function automatic logic [65:0] ref_add(input int w, input longint ua,
                                            input longint ub, input longint c);
        longint total, mask, half, sa, sb, ssum;
        logic [65:0] r;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        total = ua + ub + c;
        sa    = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb    = (ub >= half) ? ub - (longint'(1) << w) : ub;
        ssum  = sa + sb + c;
        r        = '0;
        r[63:0]  = 64'(total & mask);
        r[64]    = ((total >> w) & 1) != 0;
        r[65]    = (ssum > half - 1) || (ssum < -half);
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [65:0] e, input logic ev);
        cmp({tag, ".valid"}, 64'(ov1), 64'(ev));
        cmp({tag, ".sum"},   64'(s1),  e[63:0]);
        cmp({tag, ".cout"},  64'(co1), 64'(e[64]));
`ifdef ADDER_OVF_EN
        cmp({tag, ".ovf"},   64'(of1), 64'(e[65]));
`endif
    endtask

    task automatic chk8(input string tag, input logic [65:0] e, input logic ev);
        cmp({tag, ".valid"}, 64'(ov8), 64'(ev));
        cmp({tag, ".sum"},   64'(s8),  e[63:0]);
        cmp({tag, ".cout"},  64'(co8), 64'(e[64]));
`ifdef ADDER_OVF_EN
        cmp({tag, ".ovf"},   64'(of8), 64'(e[65]));
`endif
    endtask

    task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic c);
        v8 = 1'b1; a8 = x; b8 = y; cin8 = c;
    endtask

    initial begin
        logic [65:0] e, last;
        logic [65:0] q[$];
        logic [7:0]  ra, rb;
        logic        rc;
        logic [2:0]  combo;

        rst_n = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        v8 = 1'b0; a8 = '0;   b8 = '0;   cin8 = 1'b0;
        tick();
        tick();
        chk1("reset_w1", '0, 1'b0);
        chk8("reset_w8", '0, 1'b0);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive, back-to-back
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            v1 = 1'b1; a1 = combo[2]; b1 = combo[1]; cin1 = combo[0];
            tick();
            chk1($sformatf("w1_abc%0d%0d%0d", combo[2], combo[1], combo[0]),
                 ref_add(1, longint'(combo[2]), longint'(combo[1]), longint'(combo[0])), 1'b1);
        end
        v1 = 1'b0;
        // Spot checks against the full-adder truth table as literal constants
        cmp("w1_111_literal", {62'd0, co1, s1}, 64'b11);
        tick();
        cmp("w1_idle_valid", 64'(ov1), 64'd0);

        // WIDTH=8 carry chain boundaries
        drive8(8'hFF, 8'h01, 1'b0); tick();
        chk8("ff_01_0", {2'b01, 64'h00}, 1'b1);
        drive8(8'hFF, 8'h00, 1'b1); tick();
        chk8("ff_00_1", {2'b01, 64'h00}, 1'b1);
        drive8(8'hFF, 8'hFF, 1'b1); tick();
        chk8("ff_ff_1", {2'b01, 64'hFF}, 1'b1);
        drive8(8'h00, 8'h00, 1'b0); tick();
        chk8("00_00_0", {2'b00, 64'h00}, 1'b1);

        // Overflow vectors (sum/cout checked in every build)
        drive8(8'h7F, 8'h01, 1'b0); tick();
        chk8("ovf_7f_01", {2'b10, 64'h80}, 1'b1);
        drive8(8'h80, 8'hFF, 1'b0); tick();
        chk8("ovf_80_ff", {2'b11, 64'h7F}, 1'b1);
        drive8(8'h10, 8'h20, 1'b1); tick();
        chk8("ovf_10_20", {2'b00, 64'h31}, 1'b1);

        // Hold with X on operands
        drive8(8'h12, 8'h34, 1'b0); tick();
        last = {2'b00, 64'h46};
        chk8("hold_load", last, 1'b1);
        v8 = 1'b0; a8 = 'x; b8 = 'x; cin8 = 1'bx;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk8($sformatf("hold_%0d", i), last, 1'b0);
        end

        // Reset has priority over in_valid and discards the pending operands
        rst_n = 1'b0;
        drive8(8'hAA, 8'h55, 1'b0);
        tick();
        chk8("rst_prio", '0, 1'b0);
        rst_n = 1'b1;
        v8 = 1'b0;
        tick();
        chk8("rst_release", '0, 1'b0);

        // Throughput: 16 random vectors back-to-back
        for (int k = 0; k < 16; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            drive8(ra, rb, rc);
            q.push_back(ref_add(8, longint'(ra), longint'(rb), longint'(rc)));
            tick();
            e = q.pop_front();
            chk8($sformatf("stream_%0d", k), e, 1'b1);
            last = e;
        end
        v8 = 1'b0;
        tick();
        chk8("stream_end", last, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
